// File: rtl/timer_controller.sv
// Memory-mapped timer peripheral: prescaled 32-bit up-counter with compare,
// optional auto-reload and a level interrupt, answering zero-wait-state bus accesses.
module timer_controller #(
  parameter int                        PRESCALE_WIDTH = 16,
  parameter logic [PRESCALE_WIDTH-1:0] PRESCALE_RESET = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_data_wr,
  input  logic [3:0]  bus_mask,
  output logic [31:0] bus_data_rd,
  output logic        bus_stall,
  output logic        irq
);

  localparam logic [2:0] REG_COUNT    = 3'd0;
  localparam logic [2:0] REG_COMPARE  = 3'd1;
  localparam logic [2:0] REG_CTRL     = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  logic [31:0]               count_q, count_d;
  logic [31:0]               compare_q, compare_d;
  logic [2:0]                ctrl_q, ctrl_d;
  logic                      pending_q, pending_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;

  logic [2:0] regSel;
  logic       wrCount, wrCompare, wrCtrl, wrStatus, wrPrescale;
  logic       tick, match;
  logic       unusedAddr;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] wrVal,
                                             input logic [3:0]  m);
    return {m[3] ? wrVal[31:24] : oldVal[31:24],
            m[2] ? wrVal[23:16] : oldVal[23:16],
            m[1] ? wrVal[15:8]  : oldVal[15:8],
            m[0] ? wrVal[7:0]   : oldVal[7:0]};
  endfunction

  assign regSel     = bus_address[4:2];
  assign unusedAddr = ^{bus_address[31:5], bus_address[1:0]};
  assign wrCount    = bus_write && (regSel == REG_COUNT);
  assign wrCompare  = bus_write && (regSel == REG_COMPARE);
  assign wrCtrl     = bus_write && (regSel == REG_CTRL);
  assign wrStatus   = bus_write && (regSel == REG_STATUS);
  assign wrPrescale = bus_write && (regSel == REG_PRESCALE);

  assign tick  = ctrl_q[0] && (psc_q == prescale_q);
  assign match = tick && (count_q == compare_q);

  // A COUNT write overrides the tick increment, but the match above still
  // sees the old COUNT; a new match beats a same-cycle PENDING clear.
  always_comb begin
    count_d    = count_q;
    compare_d  = compare_q;
    ctrl_d     = ctrl_q;
    pending_d  = pending_q;
    prescale_d = prescale_q;
    psc_d      = psc_q;

    if (tick) begin
      count_d = (match && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
    end
    if (!ctrl_q[0] || tick) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + PRESCALE_WIDTH'(1);
    end

    if (wrCount) begin
      count_d = mergeBytes(count_q, bus_data_wr, bus_mask);
    end
    if (wrCompare) begin
      compare_d = mergeBytes(compare_q, bus_data_wr, bus_mask);
    end
    if (wrCtrl) begin
      if (bus_mask[0]) begin
        ctrl_d = bus_data_wr[2:0];
      end
      psc_d = '0;
    end
    if (wrPrescale) begin
      prescale_d = PRESCALE_WIDTH'(mergeBytes(32'(prescale_q), bus_data_wr, bus_mask));
      psc_d      = '0;
    end
    if (wrStatus && bus_mask[0] && bus_data_wr[0]) begin
      pending_d = 1'b0;
    end
    if (match) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 32'd0;
      compare_q  <= 32'hFFFF_FFFF;
      ctrl_q     <= 3'd0;
      pending_q  <= 1'b0;
      prescale_q <= PRESCALE_RESET;
      psc_q      <= '0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      ctrl_q     <= ctrl_d;
      pending_q  <= pending_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
    end
  end

  always_comb begin
    bus_data_rd = 32'd0;
    if (bus_read) begin
      case (regSel)
        REG_COUNT:    bus_data_rd = count_q;
        REG_COMPARE:  bus_data_rd = compare_q;
        REG_CTRL:     bus_data_rd = {29'd0, ctrl_q};
        REG_STATUS:   bus_data_rd = {31'd0, pending_q};
        REG_PRESCALE: bus_data_rd = 32'(prescale_q);
        default:      bus_data_rd = 32'd0;
      endcase
    end
  end

  assign bus_stall = 1'b0;
  assign irq       = pending_q & ctrl_q[2];

endmodule
